// File: rtl/id_operand_stage_pkg.sv
// Shared decode-stage definitions: stall bus layout, register index width and
// the instruction-capture state encoding.
package id_operand_stage_pkg;

    localparam int   STALL_BUS_W = 6;
    localparam int   STALL_ID    = 1;
    localparam int   STALL_EX    = 2;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;

    localparam int   REG_AW      = 5;
    localparam int   PC_W        = 32;
    localparam int   IF_TO_ID_WD = 1 + PC_W;

    typedef enum logic {
        LIVE = 1'b0,
        HELD = 1'b1
    } cap_state_e;

    function automatic logic [REG_AW-1:0] inst_rs(input logic [31:0] inst);
        return inst[25:21];
    endfunction

    function automatic logic [REG_AW-1:0] inst_rt(input logic [31:0] inst);
        return inst[20:16];
    endfunction

endpackage

// File: rtl/id_operand_stage_fwd_sel.sv
// Priority operand mux for one source register: youngest forwarding source
// first, then the writeback bypass, then the register file.
module fwd_sel
    import id_operand_stage_pkg::*;
#(
    parameter int NFWD = 2,
    parameter int XLEN = 32
) (
    input  logic [REG_AW-1:0]      addr,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*REG_AW-1:0] fwd_waddr,
    input  logic [NFWD*XLEN-1:0]   fwd_wdata,
    input  logic [NFWD-1:0]        fwd_is_load,
    input  logic                   wb_we,
    input  logic [REG_AW-1:0]      wb_waddr,
    input  logic [XLEN-1:0]        wb_wdata,
    input  logic [XLEN-1:0]        rf_data,
    output logic [XLEN-1:0]        data,
    output logic                   hit_load
);

    logic [NFWD-1:0] match;

    generate
        for (genvar gi = 0; gi < NFWD; gi++) begin : g_match
            assign match[gi] = fwd_we[gi] && (fwd_waddr[gi*REG_AW +: REG_AW] == addr);
        end
    endgenerate

    // Walk from oldest to youngest so the lowest matching index overrides.
    always_comb begin
        data     = rf_data;
        hit_load = 1'b0;
        if (wb_we && (wb_waddr == addr)) begin
            data = wb_wdata;
        end
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (match[i]) begin
                data     = fwd_wdata[i*XLEN +: XLEN];
                hit_load = fwd_is_load[i];
            end
        end
        if (addr == '0) begin
            data     = '0;
            hit_load = 1'b0;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage front end: IF->ID register, stall-safe instruction capture,
// register file with forwarding/bypass resolution and load-use detection.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NFWD    = 2,
    parameter int STALL_W = STALL_BUS_W,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic                   if_valid,
    input  logic [31:0]            if_pc,
    input  logic [31:0]            inst_sram_rdata,
    input  logic                   use_rs,
    input  logic                   use_rt,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*REG_AW-1:0] fwd_waddr,
    input  logic [NFWD*XLEN-1:0]   fwd_wdata,
    input  logic [NFWD-1:0]        fwd_is_load,
    input  logic                   wb_we,
    input  logic [REG_AW-1:0]      wb_waddr,
    input  logic [XLEN-1:0]        wb_wdata,
    output logic                   id_valid,
    output logic [31:0]            id_pc,
    output logic [31:0]            id_inst,
    output logic [XLEN-1:0]        rs_data,
    output logic [XLEN-1:0]        rt_data,
    output logic                   stallreq,
    output logic [CNT_W-1:0]       lu_stall_cnt
);

    logic [IF_TO_ID_WD-1:0] if_to_id_reg;
    cap_state_e             state_reg, state_next;
    logic [31:0]            hold_inst_reg, hold_inst_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [XLEN-1:0]        rf_mem [32];
    logic [XLEN-1:0]        rs_rf, rt_rf;
    logic                   rs_hit_load, rt_hit_load;
    logic [REG_AW-1:0]      rs_addr, rt_addr;
    logic                   id_stop, bubble;
    logic                   unused_stall_bits;

    assign unused_stall_bits = ^{stall[0], stall[STALL_W-1:3]};

    assign id_stop = (stall[STALL_ID] == Stop);
    assign bubble  = id_stop && (stall[STALL_EX] == NoStop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if_to_id_reg <= '0;
        end else if (bubble) begin
            if_to_id_reg[IF_TO_ID_WD-1] <= 1'b0;
        end else if (!id_stop) begin
            if_to_id_reg <= {if_valid, if_pc};
        end
    end

    assign id_valid = if_to_id_reg[IF_TO_ID_WD-1];
    assign id_pc    = if_to_id_reg[PC_W-1:0];

    // The SRAM output only lasts one cycle, so the word is latched on the
    // first stalled cycle and replayed until ID is allowed to advance.
    always_comb begin
        state_next     = state_reg;
        hold_inst_next = hold_inst_reg;
        if (flush || bubble) begin
            state_next = LIVE;
        end else begin
            case (state_reg)
                LIVE: begin
                    if (id_valid && id_stop) begin
                        state_next     = HELD;
                        hold_inst_next = inst_sram_rdata;
                    end
                end
                HELD: begin
                    if (!id_stop) begin
                        state_next = LIVE;
                    end
                end
                default: state_next = LIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LIVE;
            hold_inst_reg <= '0;
        end else begin
            state_reg     <= state_next;
            hold_inst_reg <= hold_inst_next;
        end
    end

    assign id_inst = !id_valid         ? 32'h0 :
                     (state_reg == HELD) ? hold_inst_reg : inst_sram_rdata;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk) begin
                if (rst) begin
                    rf_mem[gi] <= '0;
                end else if (wb_we && (wb_waddr == REG_AW'(gi)) && (gi != 0)) begin
                    rf_mem[gi] <= wb_wdata;
                end
            end
        end
    endgenerate

    assign rs_addr = inst_rs(id_inst);
    assign rt_addr = inst_rt(id_inst);
    assign rs_rf   = rf_mem[rs_addr];
    assign rt_rf   = rf_mem[rt_addr];

    fwd_sel #(.NFWD(NFWD), .XLEN(XLEN)) u_fwd_rs (
        .addr(rs_addr), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .fwd_is_load(fwd_is_load), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .rf_data(rs_rf), .data(rs_data), .hit_load(rs_hit_load)
    );

    fwd_sel #(.NFWD(NFWD), .XLEN(XLEN)) u_fwd_rt (
        .addr(rt_addr), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .fwd_is_load(fwd_is_load), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .rf_data(rt_rf), .data(rt_data), .hit_load(rt_hit_load)
    );

    assign stallreq = id_valid && !flush &&
                      ((use_rs && rs_hit_load) || (use_rt && rt_hit_load));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (stallreq && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign lu_stall_cnt = cnt_reg;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: operand-resolution vector table plus
// hand sequences for reset, stall capture, bubbles, flush and the stall counter.
module tb_id_operand_stage;

    localparam int XLEN  = 32;
    localparam int NFWD  = 2;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       stall;
    logic             flush;
    logic             if_valid;
    logic [31:0]      if_pc;
    logic [31:0]      inst_sram_rdata;
    logic             use_rs, use_rt;
    logic [1:0]       fwd_we;
    logic [9:0]       fwd_waddr;
    logic [63:0]      fwd_wdata;
    logic [1:0]       fwd_is_load;
    logic             wb_we;
    logic [4:0]       wb_waddr;
    logic [31:0]      wb_wdata;
    logic             id_valid;
    logic [31:0]      id_pc, id_inst, rs_data, rt_data;
    logic             stallreq;
    logic [CNT_W-1:0] lu_stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    id_operand_stage #(.XLEN(XLEN), .NFWD(NFWD), .STALL_W(6), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
        .use_rs(use_rs), .use_rt(use_rt),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .rs_data(rs_data), .rt_data(rt_data),
        .stallreq(stallreq), .lu_stall_cnt(lu_stall_cnt)
    );

    typedef struct {
        logic [4:0]  rs, rt;
        logic [1:0]  we;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  ld;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        urs, urt;
        logic        chk_ops;
        logic [31:0] exp_rs, exp_rt;
        logic        exp_sr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %-22s act=%08h exp=%08h ok", name, act, exp);
        end else begin
            $display("FAIL %-22s act=%08h exp=%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h23, rs, rt, 16'h0004};
    endfunction

    task automatic clear_fwd();
        fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_is_load = '0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0; use_rs = 1'b0; use_rt = 1'b0;
    endtask

    // fwd0 load to $9, rt=$9 consumer
    task automatic set_hazard();
        inst_sram_rdata = mk(5'd0, 5'd9);
        fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd9}; fwd_wdata = {32'h0, 32'h0};
        fwd_is_load = 2'b01; use_rt = 1'b1;
    endtask

    initial begin
        //      rs  rt  we     a0  a1  d0     d1     ld     wbe wba d33    urs urt chk exp_rs exp_rt  sr
        vecs[0] = '{5'd8, 5'd0, 2'b11, 5'd8, 5'd8, 32'h11, 32'h22, 2'b00, 1'b1, 5'd8, 32'h33, 1'b1, 1'b0, 1'b1, 32'h11, 32'h0, 1'b0};
        vecs[1] = '{5'd8, 5'd0, 2'b10, 5'd8, 5'd8, 32'h11, 32'h22, 2'b00, 1'b1, 5'd8, 32'h33, 1'b1, 1'b0, 1'b1, 32'h22, 32'h0, 1'b0};
        vecs[2] = '{5'd8, 5'd0, 2'b00, 5'd8, 5'd8, 32'h11, 32'h22, 2'b00, 1'b1, 5'd8, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 32'h0, 1'b0};
        vecs[3] = '{5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'h11, 32'h22, 2'b00, 1'b1, 5'd0, 32'h33, 1'b1, 1'b1, 1'b1, 32'h0,  32'h0, 1'b0};
        vecs[4] = '{5'd0, 5'd9, 2'b11, 5'd9, 5'd9, 32'h7,  32'h99, 2'b10, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0,  32'h7, 1'b0};
        vecs[5] = '{5'd0, 5'd9, 2'b01, 5'd9, 5'd0, 32'h44, 32'h0,  2'b01, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  32'h0, 1'b1};
        vecs[6] = '{5'd0, 5'd9, 2'b01, 5'd9, 5'd0, 32'h44, 32'h0,  2'b01, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0,  32'h44, 1'b0};
        vecs[7] = '{5'd3, 5'd4, 2'b10, 5'd0, 5'd3, 32'h0,  32'hA,  2'b00, 1'b1, 5'd4, 32'hB,  1'b1, 1'b1, 1'b1, 32'hA,  32'hB, 1'b0};
        vecs[8] = '{5'd5, 5'd0, 2'b11, 5'd6, 5'd5, 32'h1,  32'h2,  2'b10, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1};
        vecs[9] = '{5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 32'h1,  32'h0,  2'b01, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h0,  32'h0, 1'b0};

        rst = 1'b1; stall = '0; flush = 1'b0; if_valid = 1'b1;
        if_pc = 32'hBFC00000; inst_sram_rdata = 32'h3C011234;
        clear_fwd();
        repeat (3) step();
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_cnt", {30'h0, lu_stall_cnt}, 32'h0);
        rst = 1'b0;
        step();
        chk("t1_id_valid", {31'h0, id_valid}, 32'h1);
        chk("t1_id_pc", id_pc, 32'hBFC00000);
        chk("t1_id_inst", id_inst, 32'h3C011234);
        chk("t1_cnt", {30'h0, lu_stall_cnt}, 32'h0);

        // stall capture: ID and EX both held for three cycles
        stall = 6'b000110;
        if_pc = 32'hBFC00004;
        for (int i = 0; i < 3; i++) begin
            step();
            inst_sram_rdata = 32'hDEADBEEF;
            #1;
            chk("t2_held_inst", id_inst, 32'h3C011234);
            chk("t2_held_pc", id_pc, 32'hBFC00000);
        end
        stall = '0;
        #1;
        chk("t2_release_cyc", id_inst, 32'h3C011234);
        step();
        chk("t2_live_inst", id_inst, 32'hDEADBEEF);
        chk("t2_live_pc", id_pc, 32'hBFC00004);

        // re-entering HELD recaptures instead of reusing the old word
        inst_sram_rdata = 32'h22222222;
        stall = 6'b000110;
        step();
        inst_sram_rdata = 32'h33333333;
        #1;
        chk("recapture", id_inst, 32'h22222222);

        // bubble from HELD: id_valid drops, then a fresh instruction is live
        stall = 6'b000010;
        step();
        chk("bubble_valid", {31'h0, id_valid}, 32'h0);
        chk("bubble_inst", id_inst, 32'h0);
        stall = '0;
        inst_sram_rdata = 32'h44444444;
        step();
        chk("post_bubble_valid", {31'h0, id_valid}, 32'h1);
        chk("post_bubble_inst", id_inst, 32'h44444444);

        // operand resolution table, combinational only
        for (int v = 0; v < 10; v++) begin
            inst_sram_rdata = mk(vecs[v].rs, vecs[v].rt);
            fwd_we = vecs[v].we;
            fwd_waddr = {vecs[v].a1, vecs[v].a0};
            fwd_wdata = {vecs[v].d1, vecs[v].d0};
            fwd_is_load = vecs[v].ld;
            wb_we = vecs[v].wbe; wb_waddr = vecs[v].wba; wb_wdata = vecs[v].wbd;
            use_rs = vecs[v].urs; use_rt = vecs[v].urt;
            #1;
            if (vecs[v].chk_ops) begin
                chk($sformatf("vec%0d_rs", v), rs_data, vecs[v].exp_rs);
                chk($sformatf("vec%0d_rt", v), rt_data, vecs[v].exp_rt);
            end
            chk($sformatf("vec%0d_stallreq", v), {31'h0, stallreq}, {31'h0, vecs[v].exp_sr});
        end
        clear_fwd();

        // regfile write through wb, then read with no bypass
        wb_we = 1'b1; wb_waddr = 5'd10; wb_wdata = 32'h0000CAFE;
        inst_sram_rdata = mk(5'd10, 5'd10);
        step();
        wb_we = 1'b0;
        #1;
        chk("rf_read_rs", rs_data, 32'h0000CAFE);
        chk("rf_read_rt", rt_data, 32'h0000CAFE);

        // load-use: one stall cycle, then the load result arrives from fwd1
        set_hazard();
        #1;
        chk("t4_stallreq", {31'h0, stallreq}, 32'h1);
        chk("t4_cnt_before", {30'h0, lu_stall_cnt}, 32'h0);
        step();
        fwd_we = 2'b10; fwd_waddr = {5'd9, 5'd0}; fwd_wdata = {32'h55, 32'h0}; fwd_is_load = 2'b00;
        #1;
        chk("t4_stallreq_clr", {31'h0, stallreq}, 32'h0);
        chk("t4_rt_data", rt_data, 32'h55);
        chk("t4_cnt", {30'h0, lu_stall_cnt}, 32'h1);

        // flush during load-use
        set_hazard();
        flush = 1'b1;
        #1;
        chk("t6_flush_stallreq", {31'h0, stallreq}, 32'h0);
        step();
        flush = 1'b0;
        #1;
        chk("t6_flush_valid", {31'h0, id_valid}, 32'h0);
        chk("t6_flush_inst", id_inst, 32'h0);
        chk("t6_cnt_unchanged", {30'h0, lu_stall_cnt}, 32'h1);
        step();
        chk("t6_revalid", {31'h0, id_valid}, 32'h1);
        repeat (5) step();
        chk("t6_cnt_sat", {30'h0, lu_stall_cnt}, 32'h3);

        // reset in the middle of a held load-use stall
        stall = 6'b000110;
        step();
        chk("rs_mid_stallreq_pre", {31'h0, stallreq}, 32'h1);
        rst = 1'b1;
        step();
        chk("rs_mid_valid", {31'h0, id_valid}, 32'h0);
        chk("rs_mid_stallreq", {31'h0, stallreq}, 32'h0);
        chk("rs_mid_cnt", {30'h0, lu_stall_cnt}, 32'h0);
        rst = 1'b0;
        stall = '0;
        clear_fwd();
        inst_sram_rdata = 32'h55555555;
        step();
        chk("rs_mid_live_inst", id_inst, 32'h55555555);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
